// File: rtl/stage_wb.sv
// RV32I write-back stage: load alignment, register-file write port,
// stall-safe load hold and the mcycle/minstret counters.
package stage_wb_pkg;

  typedef struct packed {
    logic        instr_valid;
    logic [31:0] pc_plus_four;
    logic [31:0] alu_result;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_sel;
    logic [4:0]  reg_wr_addr;
    logic [1:0]  dmem_size;
    logic        dmem_sign;
  } ma_wb_reg_t;

endpackage

module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        stall_i,
  input  ma_wb_reg_t  ma_wb_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        cnt_wr_en_i,
  input  logic [1:0]  cnt_wr_sel_i,
  input  logic [31:0] cnt_wr_data_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o,
  output logic        retire_o,
  output logic [63:0] mcycle_o,
  output logic [63:0] minstret_o
);

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_e;

  hold_e       state_q;
  hold_e       state_d;
  logic [31:0] ld_hold_r;
  logic        ld_held;
  logic        capture;
  logic        fire;
  logic [31:0] raw;
  logic [31:0] ld_data;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
  logic        mcyc_wr;
  logic        mret_wr;
  logic        unused_param;

  assign unused_param = RESET_PC_UNUSED != 0;

  assign fire = ma_wb_i.instr_valid & ~stall_i & ~rst_i;

  assign retire_o = fire;

  assign rf_wr_en_o = fire
                    & ma_wb_i.reg_wr_en
                    & (ma_wb_i.reg_wr_addr != 5'd0);

  assign rf_wr_addr_o = ma_wb_i.reg_wr_addr;

  // Memory read data is only valid for one cycle, so freeze it on stall entry.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LIVE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LIVE: if (stall_i & ma_wb_i.instr_valid) state_d = HELD;
      HELD: if (!stall_i) state_d = LIVE;
      default: state_d = LIVE;
    endcase
  end

  always_comb begin
    ld_held = state_q == HELD;
    capture = (state_q == LIVE) & stall_i & ma_wb_i.instr_valid;
    raw     = ld_held ? ld_hold_r : dmem_rdata_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ld_hold_r <= 32'h0;
    end else if (capture) begin
      ld_hold_r <= dmem_rdata_i;
    end
  end

  function automatic logic [31:0] align(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    unique case (1'b1)
      size == 2'b00: r = {{24{sgn & b[7]}}, b};
      size == 2'b01: r = {{16{sgn & h[15]}}, h};
      default:       r = word;
    endcase
    return r;
  endfunction

  assign ld_data = align(raw,
                         ma_wb_i.alu_result[1:0],
                         ma_wb_i.dmem_size,
                         ma_wb_i.dmem_sign);

  always_comb begin
    rf_wr_data_o = 32'h0;
    unique case (ma_wb_i.reg_wr_sel)
      2'b00: rf_wr_data_o = ma_wb_i.alu_result;
      2'b01: rf_wr_data_o = ld_data;
      2'b10: rf_wr_data_o = ma_wb_i.pc_plus_four;
      2'b11: rf_wr_data_o = 32'h0;
      default: rf_wr_data_o = 32'h0;
    endcase
  end

  assign mcyc_wr = cnt_wr_en_i & ~cnt_wr_sel_i[1];
  assign mret_wr = cnt_wr_en_i & cnt_wr_sel_i[1];

  // A CSR write owns its counter for the cycle: no increment, no carry.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q <= 64'h0;
    end else if (mcyc_wr) begin
      if (cnt_wr_sel_i[0]) begin
        mcycle_q[63:32] <= cnt_wr_data_i;
      end else begin
        mcycle_q[31:0] <= cnt_wr_data_i;
      end
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      minstret_q <= 64'h0;
    end else if (mret_wr) begin
      if (cnt_wr_sel_i[0]) begin
        minstret_q[63:32] <= cnt_wr_data_i;
      end else begin
        minstret_q[31:0] <= cnt_wr_data_i;
      end
    end else if (retire_o) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end

  assign mcycle_o   = mcycle_q;
  assign minstret_o = minstret_q;

endmodule

// File: tb/tb_stage_wb.sv
// Directed bench for stage_wb: write-back select, load alignment,
// stall hold, counters and asynchronous reset.
module tb_stage_wb;
  import stage_wb_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  ma_wb_reg_t  mw;
  logic [31:0] rdata;
  logic        cwe;
  logic [1:0]  csel;
  logic [31:0] cdat;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        retire;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  int checks = 0;
  int failures = 0;

  stage_wb #(.RESET_PC_UNUSED(0)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .ma_wb_i      (mw),
    .dmem_rdata_i (rdata),
    .cnt_wr_en_i  (cwe),
    .cnt_wr_sel_i (csel),
    .cnt_wr_data_i(cdat),
    .rf_wr_en_o   (rf_we),
    .rf_wr_addr_o (rf_wa),
    .rf_wr_data_o (rf_wd),
    .retire_o     (retire),
    .mcycle_o     (mcycle),
    .minstret_o   (minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic        v,
                       input logic        we,
                       input logic [1:0]  sel,
                       input logic [4:0]  a,
                       input logic [31:0] alu,
                       input logic [1:0]  sz,
                       input logic        sg);
    mw.instr_valid  = v;
    mw.reg_wr_en    = we;
    mw.reg_wr_sel   = sel;
    mw.reg_wr_addr  = a;
    mw.alu_result   = alu;
    mw.dmem_size    = sz;
    mw.dmem_sign    = sg;
    mw.pc_plus_four = 32'h0;
  endtask

  initial begin
    rst_i   = 1'b1;
    stall_i = 1'b0;
    rdata   = 32'h0;
    cwe     = 1'b0;
    csel    = 2'b00;
    cdat    = 32'h0;
    instr(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234_5678, 2'b10, 1'b0);
    #12;
    chk("rst_we", {63'h0, rf_we}, 64'h0);
    chk("rst_ret", {63'h0, retire}, 64'h0);
    chk("rst_mcyc", mcycle, 64'h0);
    chk("rst_mret", minstret, 64'h0);

    // release reset away from an edge
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("alu_we", {63'h0, rf_we}, 64'h1);
    chk("alu_wa", {59'h0, rf_wa}, 64'd5);
    chk("alu_wd", {32'h0, rf_wd}, 64'h1234_5678);
    chk("alu_ret", {63'h0, retire}, 64'h1);
    chk("alu_mret0", minstret, 64'd0);
    edge_step();
    chk("alu_mret1", minstret, 64'd1);

    rdata = 32'h80FF_7F01;
    instr(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_1003, 2'b00, 1'b1);
    #1;
    chk("lb", {32'h0, rf_wd}, 64'hFFFF_FF80);
    edge_step();
    instr(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_1002, 2'b00, 1'b0);
    #1;
    chk("lbu", {32'h0, rf_wd}, 64'h0000_00FF);
    edge_step();
    instr(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_1002, 2'b01, 1'b1);
    #1;
    chk("lh", {32'h0, rf_wd}, 64'hFFFF_80FF);
    edge_step();
    chk("ld_mret", minstret, 64'd4);

    // LW stalled three edges; memory word changes after the first
    instr(1'b1, 1'b1, 2'b01, 5'd7, 32'h0000_2000, 2'b10, 1'b0);
    stall_i = 1'b1;
    rdata = 32'hCAFE_F00D;
    #1;
    chk("stl_we0", {63'h0, rf_we}, 64'h0);
    chk("stl_ret0", {63'h0, retire}, 64'h0);
    edge_step();
    rdata = 32'hDEAD_BEEF;
    #1;
    chk("stl_we1", {63'h0, rf_we}, 64'h0);
    chk("stl_wd1", {32'h0, rf_wd}, 64'hCAFE_F00D);
    edge_step();
    edge_step();
    chk("stl_mret", minstret, 64'd4);
    stall_i = 1'b0;
    #1;
    chk("rel_we", {63'h0, rf_we}, 64'h1);
    chk("rel_wd", {32'h0, rf_wd}, 64'hCAFE_F00D);
    chk("rel_ret", {63'h0, retire}, 64'h1);
    edge_step();
    chk("rel_mret", minstret, 64'd5);
    #1;
    chk("live_wd", {32'h0, rf_wd}, 64'hDEAD_BEEF);
    edge_step();

    instr(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0055, 2'b10, 1'b0);
    #1;
    chk("x0_we", {63'h0, rf_we}, 64'h0);
    chk("x0_ret", {63'h0, retire}, 64'h1);
    edge_step();
    chk("x0_mret", minstret, 64'd7);
    instr(1'b0, 1'b1, 2'b00, 5'd4, 32'h0000_0055, 2'b10, 1'b0);
    #1;
    chk("inv_we", {63'h0, rf_we}, 64'h0);
    chk("inv_ret", {63'h0, retire}, 64'h0);
    edge_step();
    chk("inv_mret", minstret, 64'd7);

    instr(1'b1, 1'b1, 2'b10, 5'd1, 32'h0000_0055, 2'b10, 1'b0);
    mw.pc_plus_four = 32'h0000_0104;
    #1;
    chk("jal_wd", {32'h0, rf_wd}, 64'h0000_0104);
    edge_step();
    instr(1'b0, 1'b1, 2'b11, 5'd1, 32'h0000_0055, 2'b10, 1'b0);
    #1;
    chk("sel11_wd", {32'h0, rf_wd}, 64'h0);

    // preload mcycle to 0x0000_0000_FFFF_FFFF
    cwe  = 1'b1;
    csel = 2'b01;
    cdat = 32'h0;
    edge_step();
    csel = 2'b00;
    cdat = 32'hFFFF_FFFF;
    edge_step();
    cwe = 1'b0;
    chk("mcyc_pre", mcycle, 64'h0000_0000_FFFF_FFFF);
    edge_step();
    chk("mcyc_carry", mcycle, 64'h0000_0001_0000_0000);

    // minstret write coincident with a retire
    instr(1'b1, 1'b1, 2'b00, 5'd3, 32'h0000_0001, 2'b10, 1'b0);
    cwe  = 1'b1;
    csel = 2'b10;
    cdat = 32'h0000_0010;
    edge_step();
    cwe = 1'b0;
    mw.instr_valid = 1'b0;
    chk("mret_wr", minstret, 64'h10);
    edge_step();
    chk("mret_hold", minstret, 64'h10);
    mw.instr_valid = 1'b1;
    edge_step();
    chk("mret_inc", minstret, 64'h11);

    // async reset while a load is held
    instr(1'b1, 1'b1, 2'b01, 5'd9, 32'h0000_3000, 2'b10, 1'b0);
    stall_i = 1'b1;
    rdata = 32'h1111_1111;
    edge_step();
    rdata = 32'h2222_2222;
    stall_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_mcyc", mcycle, 64'h0);
    chk("arst_mret", minstret, 64'h0);
    chk("arst_we", {63'h0, rf_we}, 64'h0);
    chk("arst_ret", {63'h0, retire}, 64'h0);
    rst_i = 1'b0;
    #1;
    chk("arst_live", {32'h0, rf_wd}, 64'h2222_2222);
    chk("arst_we1", {63'h0, rf_we}, 64'h1);
    edge_step();
    chk("arst_mret1", minstret, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
